// File: rtl/kanagawa_hal_credit_chain_pkg.sv
// Shared constants and helpers for the credit-based pipeline chain.
package kanagawa_hal_credit_chain_pkg;

    localparam int MAX_STAGE_DEPTH = 99;

    // Smallest receive buffer that covers the full credit loop latency.
    function automatic int min_full_rate_fifo_depth(input int fwd_depth, input int bwd_depth);
        return fwd_depth + bwd_depth + 2;
    endfunction

endpackage

// File: rtl/kanagawa_hal_credit_fifo.sv
// Show-ahead receive buffer of the credit chain; head word is visible while !empty.
module kanagawa_hal_credit_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("kanagawa_hal_credit_fifo: FIFO_DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // A write into a full buffer is only legal when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kanagawa_hal_credit_pipeline_chain.sv
// Credit-flow-controlled register chain: retimable forward and credit-return stages feeding a receive FIFO.
// Optional protocol checker compiled in with `define KANAGAWA_HAL_CREDIT_CHAIN_CHECK_EN.
module kanagawa_hal_credit_pipeline_chain
    import kanagawa_hal_credit_chain_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FWD_DEPTH  = 2,
    parameter int BWD_DEPTH  = 2,
    parameter int FIFO_DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             error
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("kanagawa_hal_credit_pipeline_chain: WIDTH must be >= 1");
    end
    if (FWD_DEPTH < 1 || FWD_DEPTH > MAX_STAGE_DEPTH) begin : g_bad_fwd
        $error("kanagawa_hal_credit_pipeline_chain: FWD_DEPTH out of range 1..99");
    end
    if (BWD_DEPTH < 1 || BWD_DEPTH > MAX_STAGE_DEPTH) begin : g_bad_bwd
        $error("kanagawa_hal_credit_pipeline_chain: BWD_DEPTH out of range 1..99");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_fifo
        $error("kanagawa_hal_credit_pipeline_chain: FIFO_DEPTH must be >= 1");
    end

    logic [CRED_W-1:0]    credits;
    logic [CRED_W-1:0]    credits_next;
    logic                 accept;
    logic                 credit_ret;
    logic                 pop;
    logic [FWD_DEPTH-1:0] fwd_valid;
    logic [WIDTH-1:0]     fwd_data [FWD_DEPTH];
    logic [BWD_DEPTH-1:0] bwd_pulse;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign in_ready   = (credits != '0);
    assign accept     = in_valid && in_ready;
    assign credit_ret = bwd_pulse[BWD_DEPTH-1];
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    // NOTE: default first so every path assigns credits_next and no latch is inferred.
    always_comb begin
        credits_next = credits;
        if (accept && !credit_ret) begin
            credits_next = credits - 1'b1;
        end else if (!accept && credit_ret) begin
            credits_next = credits + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits   <= CRED_W'(FIFO_DEPTH);
            fwd_valid <= '0;
            bwd_pulse <= '0;
        end else begin
            credits      <= credits_next;
            fwd_valid[0] <= accept;
            bwd_pulse[0] <= pop;
            for (int i = 1; i < FWD_DEPTH; i++) fwd_valid[i] <= fwd_valid[i-1];
            for (int i = 1; i < BWD_DEPTH; i++) bwd_pulse[i] <= bwd_pulse[i-1];
        end
    end

    // Data stages load every cycle; the matching valid bit says whether they mean anything.
    always_ff @(posedge clk) begin
        fwd_data[0] <= in_data;
        for (int i = 1; i < FWD_DEPTH; i++) fwd_data[i] <= fwd_data[i-1];
    end

    kanagawa_hal_credit_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fwd_valid[FWD_DEPTH-1]),
        .wr_data (fwd_data[FWD_DEPTH-1]),
        .rd_en   (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef KANAGAWA_HAL_CREDIT_CHAIN_CHECK_EN
    logic error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if ((fwd_valid[FWD_DEPTH-1] && fifo_full && !pop) ||
                     (pop && fifo_empty) ||
                     (credits > CRED_W'(FIFO_DEPTH))) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    logic unused_full;
    assign unused_full = fifo_full;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_kanagawa_hal_credit_pipeline_chain.sv
// Directed bench for the credit pipeline chain: default instance plus a FWD=5/BWD=1/FIFO=3 instance.
module tb_kanagawa_hal_credit_pipeline_chain;

`ifdef KANAGAWA_HAL_CREDIT_CHAIN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        error;

    logic        r_in_valid;
    logic [31:0] r_in_data;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_ready;
    logic        r_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kanagawa_hal_credit_pipeline_chain dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .error     (error)
    );

    kanagawa_hal_credit_pipeline_chain #(
        .WIDTH      (32),
        .FWD_DEPTH  (5),
        .BWD_DEPTH  (1),
        .FIFO_DEPTH (3)
    ) dut_r (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_in_valid),
        .in_data   (r_in_data),
        .in_ready  (r_in_ready),
        .out_valid (r_out_valid),
        .out_data  (r_out_data),
        .out_ready (r_out_ready),
        .error     (r_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b0;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_during got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_during got=%b exp=0", out_valid); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error_during got=%b exp=0", error); end
        repeat (2) step();
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_after got=%b exp=0", out_valid); end
        checks++; if (error !== 1'b0 || r_error !== 1'b0) begin errors++; $display("FAIL rst_error_after got=%b/%b exp=0/0", error, r_error); end
        checks++; if (r_in_ready !== 1'b1 || r_out_valid !== 1'b0) begin errors++; $display("FAIL rst_small_chain got ready=%b valid=%b exp 1/0", r_in_ready, r_out_valid); end
    endtask

    task automatic test_single_word();
        repeat (3) step();
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; in_data = 32'h0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_c1 got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_c2 got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_c3 got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_c3 got=%h exp=deadbeef", out_data); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL single_error got=%b exp=0", error); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_popped_c4 got=%b exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        int  sent = 0;
        int  got = 0;
        int  drops = 0;
        bit  started = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 1300 && got < 1000; cyc++) begin
            in_valid = (sent < 1000);
            in_data  = 32'(sent);
            #1;
            if (started && sent < 1000 && !in_ready) drops++;
            if (in_valid && in_ready) begin
                sent++;
                started = 1'b1;
            end
            if (out_valid) begin
                checks++;
                if (out_data !== 32'(got)) begin
                    errors++;
                    $display("FAIL stream_data idx=%0d got=%0d exp=%0d", got, out_data, got);
                end
                got++;
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (drops != 0) begin errors++; $display("FAIL stream_in_ready_drops got=%0d exp=0", drops); end
        checks++; if (got != 1000 || sent != 1000) begin errors++; $display("FAIL stream_count got=%0d sent=%0d exp=1000", got, sent); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int acc2 = 0;
        int k = 0;
        repeat (5) step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            in_data = 32'h100 + 32'(acc);
            #1;
            if (in_ready) acc++;
            step();
        end
        checks++; if (acc != 6) begin errors++; $display("FAIL bp_accepts got=%0d exp=6", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stalled got=%b exp=0", in_ready); end
        in_data   = 32'h106;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h100) begin errors++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=00000100", out_valid, out_data); end
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_p1 got=%b exp=0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_p2 got=%b exp=0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_p3 got=%b exp=1", in_ready); end
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_data = 32'h106 + 32'(acc2);
            #1;
            if (in_ready) acc2++;
            step();
        end
        checks++; if (acc2 != 1) begin errors++; $display("FAIL bp_extra_accepts got=%0d exp=1", acc2); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid) begin
                checks++;
                if (out_data !== 32'h101 + 32'(k)) begin
                    errors++;
                    $display("FAIL bp_drain idx=%0d got=%h exp=%h", k, out_data, 32'h101 + 32'(k));
                end
                k++;
            end
            step();
        end
        checks++; if (k != 6) begin errors++; $display("FAIL bp_drain_count got=%0d exp=6", k); end
    endtask

    task automatic test_midflight_reset();
        int acc = 0;
        int stale = 0;
        repeat (5) step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_data = 32'hA0 + 32'(cyc);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL mid_accepts got=%0d exp=4", acc); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (dut.credits !== 3'd6 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_credits got=%0d ready=%b exp=6/1", dut.credits, in_ready); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (out_valid) stale++;
            step();
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale got=%0d exp=0", stale); end
        checks++; if (dut.credits !== 3'd6) begin errors++; $display("FAIL mid_credits_after got=%0d exp=6", dut.credits); end
    endtask

    task automatic test_random_small();
        logic [31:0] q[$];
        logic [31:0] exp_word;
        repeat (3) step();
        for (int cyc = 0; cyc < 540; cyc++) begin
            if (cyc < 500) begin
                r_in_valid  = 1'($urandom_range(0, 1));
                r_in_data   = $urandom;
                r_out_ready = 1'($urandom_range(0, 1));
            end else begin
                r_in_valid  = 1'b0;
                r_out_ready = 1'b1;
            end
            #1;
            if (r_in_valid && r_in_ready) q.push_back(r_in_data);
            if (r_out_valid && r_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious got=%h exp=no word", r_out_data);
                end else begin
                    exp_word = q.pop_front();
                    if (r_out_data !== exp_word) begin
                        errors++;
                        $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, r_out_data, exp_word);
                    end
                end
            end
            step();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
        checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL rand_error got=%b exp=0", r_error); end
        checks++; if (dut_r.credits !== 2'd3) begin errors++; $display("FAIL rand_credits got=%0d exp=3", dut_r.credits); end
    endtask

    task automatic test_check_logic();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_data = 32'hC0 + 32'(cyc);
            step();
        end
        checks++; if (in_ready !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL chk_full_state got ready=%b err=%b exp 0/0", in_ready, error); end
        force dut.credits = 3'd3;
        repeat (2) step();
        release dut.credits;
        in_valid = 1'b0;
        repeat (4) step();
        checks++; if (error !== CHECK_EN) begin errors++; $display("FAIL chk_error_rise got=%b exp=%b", error, CHECK_EN); end
        repeat (5) step();
        checks++; if (error !== CHECK_EN) begin errors++; $display("FAIL chk_error_sticky got=%b exp=%b", error, CHECK_EN); end
        rst = 1'b1;
        #1;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL chk_error_cleared got=%b exp=0", error); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_midflight_reset();
        test_random_small();
        test_check_logic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kanagawa_hal_credit_pipeline_chain.md
KANAGAWA_HAL_CREDIT_PIPELINE_CHAIN -- requirements
Module: kanagawa_hal_credit_pipeline_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter FWD_DEPTH, default 2, forward register stages for valid+data (1..99).
REQ-003 SHALL have parameter BWD_DEPTH, default 2, register stages on the credit-return path (1..99).
REQ-004 SHALL have parameter FIFO_DEPTH, default 6, receive-buffer entries (>=1); full throughput requires FIFO_DEPTH >= FWD_DEPTH+BWD_DEPTH+2.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, upstream offers in_data.
REQ-008 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-009 SHALL have port in_ready, output, 1, chain accepts this cycle.
REQ-010 SHALL have port out_valid, output, 1, out_data holds the oldest buffered word.
REQ-011 SHALL have port out_data, output, WIDTH, downstream payload.
REQ-012 SHALL have port out_ready, input, 1, downstream consumes.
REQ-013 SHALL have port error, output, 1, sticky protocol-error flag.

Function
REQ-014 SHALL keep a send-side credit counter, width clog2(FIFO_DEPTH+1), reset to FIFO_DEPTH; in_ready = (credits != 0), with no combinational path from out_ready.
REQ-015 SHALL accept a word when in_valid && in_ready, decrementing credits by 1.
REQ-016 SHALL propagate an accepted word through exactly FWD_DEPTH valid+data stages, then write it into the receive FIFO.
REQ-017 SHALL present out_valid/out_data from the FIFO head in show-ahead form; a word accepted at cycle t into an empty chain appears on out_valid at cycle t+FWD_DEPTH+1.
REQ-018 SHALL pop the FIFO head on out_valid && out_ready and launch one credit-return pulse through BWD_DEPTH stages; credits increment in the cycle the pulse exits, so in_ready rises at t+BWD_DEPTH+1 after a pop at t from zero credits.
REQ-019 SHALL leave credits unchanged when an accept and a returning credit coincide.
REQ-020 SHALL preserve strict FIFO order with no loss or duplication, and support a FIFO write and pop in the same cycle, including when the FIFO is full.
REQ-021 SHALL ignore in_data and never advance the pipeline when in_valid is low; bubble stages carry valid=0.
REQ-022 SHALL sustain one word per cycle indefinitely when out_ready is held high and FIFO_DEPTH >= FWD_DEPTH+BWD_DEPTH+2.
REQ-023 SHALL make forward and credit stages plain enable-free registers, so the EDA tool can retime them.

Reset
REQ-024 SHALL on rst clear all stage valids, credit-return pulses, FIFO pointers and error, and set credits to FIFO_DEPTH; in_ready=1, out_valid=0, error=0 during and after reset.
REQ-025 SHALL discard in-flight words and credits when rst is asserted mid-transfer; none reappear after reset.
REQ-026 SHALL not reset data registers or FIFO storage.

Configuration
REQ-027 SHALL compile, when KANAGAWA_HAL_CREDIT_CHAIN_CHECK_EN is defined, logic setting error sticky-high on a FIFO write while full without a simultaneous pop, a pop while empty, or credits exceeding FIFO_DEPTH.
REQ-028 SHALL tie error to 0 and instantiate no checking logic when the macro is undefined.
REQ-029 SHALL reject illegal parameter values with elaboration-time $error in both configurations.

Structure
REQ-030 SHALL place in package kanagawa_hal_credit_chain_pkg the depth limit constant (99) and a function returning the minimum full-throughput FIFO_DEPTH for given FWD_DEPTH/BWD_DEPTH.
REQ-031 SHALL implement the receive buffer as sub-module kanagawa_hal_credit_fifo (WIDTH, FIFO_DEPTH; show-ahead; exposes full/empty).

Verification
REQ-032 SHALL cover single word: defaults, after reset send 0xDEADBEEF at cycle 0, out_ready=1 -> out_valid high at cycle 3 with 0xDEADBEEF, error=0.
REQ-033 SHALL cover streaming: 1000 consecutive incrementing words with out_ready=1 -> in_ready never drops after the first accept, output sequence 0..999 in order.
REQ-034 SHALL cover backpressure: out_ready=0, in_valid=1 -> exactly 6 accepts, then in_ready=0; raise out_ready for one cycle -> in_ready returns 3 cycles after the pop, exactly one more accept.
REQ-035 SHALL cover mid-flight reset: 4 words accepted, rst asserted 1 cycle asynchronously -> out_valid=0, credits back to 6, no stale word emitted afterward.
REQ-036 SHALL cover random out_ready (50%) and random in_valid with FWD_DEPTH=5, BWD_DEPTH=1, FIFO_DEPTH=3 -> scoreboard matches, no overflow, error=0 with the check macro defined.
REQ-037 SHALL cover check logic: macro defined, FIFO forced to overflow via a forced credit value -> error rises and stays high until rst.
